interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 20 ++
 rtl/interrupt_controller.sv | 105 ++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// Bus address/strobe and interrupt handshake lines shared by peripherals, CPU and the controller.
// BUS_DATA stays a plain inout on the controller so tristate resolution stays at module level.
interface interrupt_controller_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [1:0] SRC_INTERRUPT_RAISE;
  logic [1:0] SRC_INTERRUPT_ACK;
  logic [1:0] CPU_INTERRUPT_RAISE;
  logic [1:0] CPU_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR, BUS_WE, SRC_INTERRUPT_RAISE, CPU_INTERRUPT_ACK,
    input  SRC_INTERRUPT_ACK, CPU_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, SRC_INTERRUPT_RAISE, CPU_INTERRUPT_ACK,
    output SRC_INTERRUPT_ACK, CPU_INTERRUPT_RAISE
  );
endinterface

// File: rtl/interrupt_controller.sv
// Two-source edge-latching interrupt controller with a 3-byte register window.
// Define INTC_READBACK_EN to make Pending/Mask readable over BUS_DATA.
module interrupt_controller #(
  parameter logic [7:0] IntcBaseAddr = 8'hE0,
  parameter logic [1:0] InitialMask  = 2'b11
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, RELEASE} state_t;

  state_t     state_q, state_n;
  logic       sel_q, sel_n;
  logic       first_q;
  logic [1:0] sync_q, prev_q, pending_q, mask_q;
  logic [1:0] edge_det, armed, sel_1h, pend_clr, pend_set, pend_n;
  logic       wr_pend, wr_mask, wr_trig, accept;

  assign wr_pend = bus.BUS_WE && (bus.BUS_ADDR == IntcBaseAddr);
  assign wr_mask = bus.BUS_WE && (bus.BUS_ADDR == IntcBaseAddr + 8'd1);
  assign wr_trig = bus.BUS_WE && (bus.BUS_ADDR == IntcBaseAddr + 8'd2);

  assign edge_det = sync_q & ~prev_q;
  assign armed    = pending_q & mask_q;
  assign sel_1h   = sel_q ? 2'b10 : 2'b01;

  // prev_q takes the raw level on the first cycle out of reset so a source
  // already high at reset release is not mistaken for an edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q  <= 2'b00;
      prev_q  <= 2'b00;
      first_q <= 1'b1;
    end else begin
      sync_q  <= bus.SRC_INTERRUPT_RAISE;
      prev_q  <= first_q ? bus.SRC_INTERRUPT_RAISE : sync_q;
      first_q <= 1'b0;
    end
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (|armed) begin
        state_n = REQUEST;
        sel_n   = ~armed[0];
      end
      REQUEST: if (bus.CPU_INTERRUPT_ACK[sel_q]) begin
        state_n = RELEASE;
        accept  = 1'b1;
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sets are OR'd in after clears, so a set wins on the same bit.
  always_comb begin
    pend_clr = (wr_pend ? BUS_DATA[1:0] : 2'b00) | (accept ? sel_1h : 2'b00);
    pend_set = edge_det | (wr_trig ? BUS_DATA[1:0] : 2'b00);
    pend_n   = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      pending_q <= 2'b00;
      mask_q    <= InitialMask;
    end else begin
      state_q   <= state_n;
      sel_q     <= sel_n;
      pending_q <= pend_n;
      if (wr_mask) mask_q <= BUS_DATA[1:0];
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign bus.CPU_INTERRUPT_RAISE = (state_q == REQUEST) ? sel_1h : 2'b00;
  assign bus.SRC_INTERRUPT_ACK   = (state_q == RELEASE) ? sel_1h : 2'b00;

`ifdef INTC_READBACK_EN
  logic [7:0] rd_q;
  logic       oe_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_q <= 8'h00;
      oe_q <= 1'b0;
    end else begin
      oe_q <= !bus.BUS_WE && ((bus.BUS_ADDR == IntcBaseAddr) ||
                              (bus.BUS_ADDR == IntcBaseAddr + 8'd1));
      rd_q <= (bus.BUS_ADDR == IntcBaseAddr) ? {6'b0, pending_q} : {6'b0, mask_q};
    end
  end

  assign BUS_DATA = oe_q ? rd_q : 8'bz;
`endif

endmodule
